// File: rtl/alu_operand_ctrl.sv
// Front-end for the TP1 ALU board: synchronises and debounces three load buttons,
// serialises their presses into operand loads and strobes the ALU once all operands are present.
module alu_operand_ctrl #(
  parameter int NB_DATA   = 8,
  parameter int NB_OP     = 6,
  parameter int DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic [2:0]         i_btn,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [2:0]         o_loaded,
  output logic               o_valid,
  output logic               o_start
);

  localparam int NB_CNT = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  logic [2:0]         r_btn_s1;
  logic [2:0]         r_btn_s2;
  logic [NB_DATA-1:0] r_sw_s1;
  logic [NB_DATA-1:0] r_sw_s2;
  logic [2:0]         w_db_lvl;
  logic [2:0]         r_db_lvl_d;
  logic [2:0]         w_evt;
  logic [2:0]         r_pending;
  logic [2:0]         w_serve;
  logic [2:0]         w_pending_next;
  logic [2:0]         w_loaded_next;
  logic               w_load;
  logic [NB_DATA-1:0] r_data_a;
  logic [NB_DATA-1:0] r_data_b;
  logic [NB_OP-1:0]   r_op;
  logic [2:0]         r_loaded;
  state_t             r_state;
  state_t             w_state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= i_btn;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= i_sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // A level change is accepted only after DB_CYCLES consecutive mismatching cycles.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic [NB_CNT-1:0] r_cnt;
      logic              r_lvl;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (r_btn_s2[gi] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          r_lvl <= ~r_lvl;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db_lvl[gi] = r_lvl;
    end
  endgenerate

  assign w_evt          = w_db_lvl & ~r_db_lvl_d;
  // Isolate the lowest pending bit: fixed priority A > B > OP.
  assign w_serve        = r_pending & 3'(~r_pending + 3'd1);
  assign w_pending_next = (r_pending | w_evt) & ~w_serve;
  assign w_load         = |w_serve;
  assign w_loaded_next  = r_loaded | w_serve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_lvl_d <= '0;
      r_pending  <= '0;
      r_loaded   <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_op       <= '0;
    end else begin
      r_db_lvl_d <= w_db_lvl;
      r_pending  <= w_pending_next;
      r_loaded   <= w_loaded_next;
      if (w_serve[0]) r_data_a <= r_sw_s2;
      if (w_serve[1]) r_data_b <= r_sw_s2;
      if (w_serve[2]) r_op     <= r_sw_s2[NB_OP-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_COLLECT;
    else        r_state <= w_state_next;
  end

  // Every load served once the set is complete yields its own START cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_load && (w_loaded_next == 3'b111)) w_state_next = ST_START;
      ST_START:   w_state_next = w_load ? ST_START : ST_READY;
      ST_READY:   if (w_load) w_state_next = ST_START;
      default:    w_state_next = ST_COLLECT;
    endcase
  end

  always_comb begin
    o_start = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      ST_START: begin
        o_start = 1'b1;
        o_valid = 1'b1;
      end
      ST_READY: o_valid = 1'b1;
      default: begin
        o_start = 1'b0;
        o_valid = 1'b0;
      end
    endcase
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;
  assign o_op     = r_op;
  assign o_loaded = r_loaded;

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Bench for alu_operand_ctrl: directed scenarios with literal expectations plus
// randomised button/switch activity checked every cycle against a behavioural model.
module tb_alu_operand_ctrl;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int DB      = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NB_DATA-1:0] sw = '0;
  logic [2:0]         btn = '0;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [2:0]         o_loaded;
  logic               o_valid;
  logic               o_start;

  always #5 clk = ~clk;

  alu_operand_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(sw), .i_btn(btn),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op),
    .o_loaded(o_loaded), .o_valid(o_valid), .o_start(o_start)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: delays, mismatch run lengths, a pending set and a start rule.
  logic [2:0]         m_b1 = '0, m_b2 = '0, m_lvl = '0, m_evt = '0, m_pend = '0, m_loaded = '0;
  logic [NB_DATA-1:0] m_sw1 = '0, m_sw2 = '0, m_a = '0, m_b = '0;
  logic [NB_OP-1:0]   m_op = '0;
  logic               m_start = 1'b0;
  int                 m_run [3] = '{0, 0, 0};
  logic [2:0]         m_serve;

  function automatic logic [2:0] lowest(input logic [2:0] p);
    for (int i = 0; i < 3; i++) if (p[i]) return 3'(1 << i);
    return 3'b000;
  endfunction

  assign m_serve = lowest(m_pend);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b1 <= '0; m_b2 <= '0; m_lvl <= '0; m_evt <= '0; m_pend <= '0; m_loaded <= '0;
      m_sw1 <= '0; m_sw2 <= '0; m_a <= '0; m_b <= '0; m_op <= '0; m_start <= 1'b0;
      for (int i = 0; i < 3; i++) m_run[i] <= 0;
    end else begin
      m_b1 <= btn; m_b2 <= m_b1; m_sw1 <= sw; m_sw2 <= m_sw1;
      for (int i = 0; i < 3; i++) begin
        if (m_b2[i] == m_lvl[i]) begin
          m_run[i] <= 0;
          m_evt[i] <= 1'b0;
        end else if (m_run[i] + 1 >= DB) begin
          m_run[i] <= 0;
          m_lvl[i] <= ~m_lvl[i];
          m_evt[i] <= ~m_lvl[i];
        end else begin
          m_run[i] <= m_run[i] + 1;
          m_evt[i] <= 1'b0;
        end
      end
      m_pend <= (m_pend | m_evt) & ~m_serve;
      if (m_serve[0]) m_a <= m_sw2;
      if (m_serve[1]) m_b <= m_sw2;
      if (m_serve[2]) m_op <= m_sw2[NB_OP-1:0];
      m_loaded <= m_loaded | m_serve;
      m_start <= (m_serve != 3'b000) && ((m_loaded | m_serve) == 3'b111);
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_data_a", 32'(o_data_a), 32'(m_a));
      chk("model_data_b", 32'(o_data_b), 32'(m_b));
      chk("model_op",     32'(o_op),     32'(m_op));
      chk("model_loaded", 32'(o_loaded), 32'(m_loaded));
      chk("model_valid",  32'(o_valid),  32'(m_loaded == 3'b111));
      chk("model_start",  32'(o_start),  32'(m_start));
    end
  end

  int start_cnt = 0;
  bit track_valid = 1'b0;
  bit valid_drop = 1'b0;
  always @(posedge clk) begin
    if (o_start) start_cnt <= start_cnt + 1;
    if (track_valid && !o_valid) valid_drop <= 1'b1;
  end

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic press(input int idx, input logic [NB_DATA-1:0] val, input int hold);
    sw = val;
    tick(4);
    btn[idx] = 1'b1;
    tick(hold);
    btn[idx] = 1'b0;
    tick(3 * DB);
  endtask

  int hold_cnt [3];

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    tick(2);
    chk("reset_outputs", 32'({o_data_a, o_data_b, o_op, o_loaded, o_valid, o_start}), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("reset_release_valid", 32'(o_valid), 32'd0);
    $display("test reset done");

    // Single load with exact latency
    sw = 8'h3C;
    tick(4);
    start_cnt = 0;
    btn[0] = 1'b1;
    tick(DB + 3);
    chk("single_before_latency", 32'(o_data_a), 32'h00);
    tick(1);
    chk("single_at_latency", 32'(o_data_a), 32'h3C);
    chk("single_loaded", 32'(o_loaded), 32'b001);
    tick(2 * DB - 4);
    btn[0] = 1'b0;
    tick(3 * DB);
    chk("single_no_start", 32'(start_cnt), 32'd0);
    $display("test single_load done");

    // Bounce rejection on B
    sw = 8'hEE;
    for (int c = 0; c < 100; ) begin
      int hi, lo;
      hi = $urandom_range(1, DB - 2);
      lo = $urandom_range(1, DB - 2);
      btn[1] = 1'b1; tick(hi);
      btn[1] = 1'b0; tick(lo);
      c += hi + lo;
    end
    tick(3 * DB);
    chk("bounce_loaded_b", 32'(o_loaded[1]), 32'd0);
    chk("bounce_data_b", 32'(o_data_b), 32'h00);
    $display("test bounce done");

    // Full sequence
    do_reset();
    start_cnt = 0;
    press(0, 8'h05, 3 * DB);
    press(1, 8'h03, 3 * DB);
    chk("full_no_early_start", 32'(start_cnt), 32'd0);
    press(2, 8'h20, 1000);
    chk("full_start_count", 32'(start_cnt), 32'd1);
    chk("full_regs", 32'({o_data_a, o_data_b, o_op}), 32'({8'h05, 8'h03, 6'h20}));
    chk("full_valid", 32'(o_valid), 32'd1);
    $display("test full_sequence done");

    // Simultaneous press from fresh reset
    do_reset();
    sw = 8'hA5;
    tick(4);
    start_cnt = 0;
    btn = 3'b111;
    tick(DB + 3);
    chk("simul_none_yet", 32'(o_loaded), 32'b000);
    tick(1);
    chk("simul_a_first", 32'(o_loaded), 32'b001);
    chk("simul_a_value", 32'(o_data_a), 32'hA5);
    tick(1);
    chk("simul_b_second", 32'(o_loaded), 32'b011);
    chk("simul_no_start_yet", 32'(o_start), 32'd0);
    tick(1);
    chk("simul_op_third", 32'(o_loaded), 32'b111);
    chk("simul_op_value", 32'(o_op), 32'h25);
    chk("simul_start_high", 32'(o_start), 32'd1);
    tick(1);
    chk("simul_start_one_cycle", 32'(o_start), 32'd0);
    btn = 3'b000;
    tick(3 * DB);
    chk("simul_start_count", 32'(start_cnt), 32'd1);
    $display("test simultaneous done");

    // Re-load B in READY
    start_cnt = 0;
    valid_drop = 1'b0;
    track_valid = 1'b1;
    press(1, 8'h7F, 3 * DB);
    track_valid = 1'b0;
    chk("reload_b_value", 32'(o_data_b), 32'h7F);
    chk("reload_start_count", 32'(start_cnt), 32'd1);
    chk("reload_valid_kept", 32'(valid_drop), 32'd0);
    $display("test reload done");

    // Async reset with pending loads, buttons held through release
    sw = 8'h11;
    tick(4);
    btn = 3'b111;
    tick(DB + 4);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({o_data_a, o_data_b, o_op, o_loaded, o_valid, o_start}), 32'd0);
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    start_cnt = 0;
    tick(DB + 3);
    chk("held_reset_none_yet", 32'(o_loaded), 32'b000);
    tick(1);
    chk("held_reset_a_loaded", 32'(o_loaded), 32'b001);
    tick(3);
    btn = 3'b000;
    tick(3 * DB);
    chk("held_reset_start_count", 32'(start_cnt), 32'd1);
    $display("test async_reset done");

    // Randomised activity
    for (int i = 0; i < 3; i++) hold_cnt[i] = $urandom_range(1, 3 * DB);
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold_cnt[i] == 0) begin
          btn[i] = ~btn[i];
          hold_cnt[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, DB - 1)
                                                    : $urandom_range(DB, 4 * DB);
        end else begin
          hold_cnt[i]--;
        end
      end
      if ($urandom_range(0, 5) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 799) == 0) do_reset();
      else tick(1);
    end
    $display("test random done");

    cmp_en = 1'b0;
    tick(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
